sprite_draw: RTL and testbench
==============================

// Module: sprite_draw
// PURPOSE
//  Overlays the 48x64 sprite image onto the VGA pixel stream. Sits directly upstream of the
//  registered image ROM: generates pixel_addr = {y[5:0], x[5:0]} from the timing counters and
//  latched sprite position, consumes the ROM's rgb one cycle later, and mixes it over rgb_in.
//  Delays the full timing bus so that outputs stay aligned with the pixel data.
// PARAMETERS
//  IMG_W      48       sprite width in pixels (x offset 0..IMG_W-1)
//  IMG_H      64       sprite height in pixels (y offset 0..IMG_H-1)
//  KEY_EN     1        1: a ROM pixel equal to KEY_RGB is transparent (rgb_in shows through)
//  KEY_RGB    12'h000  transparent colour key
// PORTS
//  clk         in   1   pixel clock
//  rst         in   1   synchronous reset, active-high
//  hcount_in   in   11  horizontal pixel counter
//  hsync_in    in   1   horizontal sync
//  hblnk_in    in   1   horizontal blanking
//  vcount_in   in   11  vertical line counter
//  vsync_in    in   1   vertical sync
//  vblnk_in    in   1   vertical blanking
//  rgb_in      in   12  background pixel {r,g,b} 4b each
//  xpos        in   12  sprite left edge (screen x); may change at any time
//  ypos        in   12  sprite top edge (screen y); may change at any time
//  rgb_pixel   in   12  image ROM data; valid 1 cycle after pixel_addr
//  pixel_addr  out  12  image ROM address {y_off[5:0], x_off[5:0]}, registered
//  hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  11/1/1/11/1/1  delayed timing
//  rgb_out     out  12  composited pixel
// BEHAVIOUR
//  - Position latch: xpos/ypos are captured into xlat/ylat in the cycle where vblnk_in rises (0->1,
//    from the registered previous vblnk_in). Mid-frame changes take effect from the next frame (no tearing).
//  - Stage 1 (edge k): x_off = hcount_in - xlat and y_off = vcount_in - ylat, both 12b unsigned.
//    inrect = (hcount_in >= xlat) && (x_off < IMG_W) && (vcount_in >= ylat) && (y_off < IMG_H).
//    pixel_addr <= inrect ? {y_off[5:0], x_off[5:0]} : 12'h000. Register inrect, rgb_in and the timing bus.
//  - Stage 2 (edge k+1): the ROM registers rgb_pixel. The block delays inrect, rgb_in and timing by one more cycle.
//  - Stage 3 (edge k+2): rgb_out <= (hblnk|vblnk) ? 12'h000
//      : (inrect && !(KEY_EN && rgb_pixel==KEY_RGB)) ? rgb_pixel : rgb_in. Timing outputs are registered in the same stage.
//  - Latency: every output equals the function of the inputs sampled 3 edges earlier (pixel_addr: 1 edge).
//    Throughput is 1 pixel/clk with no stalls.
//  - Clipping: a sprite partly past the screen's right or bottom edge draws only its visible part.
//    When xlat/ylat is beyond the counter range, nothing is drawn. No wrap-around to the left or top.
//  - Comparisons use 12-bit zero-extended hcount and vcount, so subtraction underflow never sets inrect.
//  - Reset (synchronous, any time incl. mid-line): all pipeline registers, pixel_addr, rgb_out and every
//    timing output go to 0. xlat = ylat = 0 and prev_vblnk = 0. The first 3 output cycles after
//    rst falls carry flushed zeros.
//  - If vblnk_in rises in the same cycle that rst is high, reset wins and no latch occurs.
// STRUCTURE
//  - Shared header vga_defs: VGA counter width (11), RGB width (12), IMG_W/IMG_H defaults,
//    and the pipeline latency constant DRAW_LAT = 3.
//  - Sub-module vga_timing_delay #(N): N-stage register delay for {hcount, hsync, hblnk, vcount, vsync,
//    vblnk}, with synchronous reset. It is instantiated with N=3 here, and rgb_in/inrect use the same delay pattern.
//  - Mixing and position latch stay inline in sprite_draw.
// TESTING
//  1. xpos=100, ypos=50 latched; feed hcount=100, vcount=50 -> pixel_addr=12'h000 next cycle; rgb_out=ROM[0] 3 cycles after input.
//  2. hcount=147, vcount=113 with the same position -> addr={6'd63,6'd47}=12'hFEF. hcount=148 -> inrect=0, rgb_out=rgb_in.
//  3. KEY_EN=1 and ROM returns 12'h000 inside the rect with rgb_in=12'hABC -> rgb_out=12'hABC. ROM returns 12'hF00 -> rgb_out=12'hF00.
//  4. Change xpos 100->300 mid-frame at vcount=60 -> the sprite stays at x=100 until vblnk rises, then
//     frame N+1 draws at x=300.
//  5. xpos=780 on an 800-wide line -> only columns 780..799 are drawn (x_off 0..19), with no wrap to x=0.
//     hblnk=1 inside the rect -> rgb_out=0.
//  6. Assert rst for 1 cycle mid-line inside the sprite -> on the next cycle all outputs are 0, and 3 cycles after
//     release the outputs track the inputs again, with xlat=ylat=0 until the next vblnk rise.

Source files
------------

// File: rtl/sprite_draw_pkg.sv
// Shared VGA definitions for the sprite overlay: counter/colour widths, sprite defaults,
// the pipeline latency and the timing-bus struct.
package sprite_draw_pkg;

   localparam int CNT_W     = 11;
   localparam int RGB_W     = 12;
   localparam int POS_W     = 12;
   localparam int ADDR_W    = 12;
   localparam int IMG_W_DEF = 48;
   localparam int IMG_H_DEF = 64;
   localparam int DRAW_LAT  = 3;

   typedef struct packed {
      logic [CNT_W-1:0] hcount;
      logic             hsync;
      logic             hblnk;
      logic [CNT_W-1:0] vcount;
      logic             vsync;
      logic             vblnk;
   } vga_timing_t;

   // Per-pixel data that travels alongside the ROM lookup.
   typedef struct packed {
      logic             blank;
      logic             inrect;
      logic [RGB_W-1:0] rgb;
   } pix_t;

endpackage

// File: rtl/vga_timing_delay.sv
// N-stage register delay for the VGA timing bus, cleared by synchronous reset.
module vga_timing_delay
   import sprite_draw_pkg::*;
#(
   parameter int N = DRAW_LAT
) (
   input  logic        clk,
   input  logic        rst,
   input  vga_timing_t tim_in,
   output vga_timing_t tim_out
);

   vga_timing_t stage_q [N];
   vga_timing_t stage_d [N];

   always_comb begin
      stage_d[0] = tim_in;
      for (int i = 1; i < N; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            stage_q[i] <= '0;
         end else begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign tim_out = stage_q[N-1];

endmodule

// File: rtl/sprite_draw.sv
// Overlays a ROM-backed sprite on the VGA stream: address generation, two-stage pixel
// pipeline matching the registered ROM, colour-key mixing and per-frame position latch.
module sprite_draw
   import sprite_draw_pkg::*;
#(
   parameter int               IMG_W   = IMG_W_DEF,
   parameter int               IMG_H   = IMG_H_DEF,
   parameter bit               KEY_EN  = 1'b1,
   parameter logic [RGB_W-1:0] KEY_RGB = 12'h000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CNT_W-1:0]  hcount_in,
   input  logic              hsync_in,
   input  logic              hblnk_in,
   input  logic [CNT_W-1:0]  vcount_in,
   input  logic              vsync_in,
   input  logic              vblnk_in,
   input  logic [RGB_W-1:0]  rgb_in,
   input  logic [POS_W-1:0]  xpos,
   input  logic [POS_W-1:0]  ypos,
   input  logic [RGB_W-1:0]  rgb_pixel,
   output logic [ADDR_W-1:0] pixel_addr,
   output logic [CNT_W-1:0]  hcount_out,
   output logic              hsync_out,
   output logic              hblnk_out,
   output logic [CNT_W-1:0]  vcount_out,
   output logic              vsync_out,
   output logic              vblnk_out,
   output logic [RGB_W-1:0]  rgb_out
);

   logic              prev_vblnk_q, prev_vblnk_d;
   logic [POS_W-1:0]  xlat_q, xlat_d;
   logic [POS_W-1:0]  ylat_q, ylat_d;
   logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
   pix_t              s1_q, s1_d;
   pix_t              s2_q, s2_d;
   logic [RGB_W-1:0]  rgb_out_q, rgb_out_d;

   logic [POS_W-1:0]  h_ext, v_ext, x_off, y_off;
   logic              inrect, is_key;

   always_comb begin
      // Latch position only on the vblank rising edge so a frame never tears.
      prev_vblnk_d = vblnk_in;
      xlat_d       = xlat_q;
      ylat_d       = ylat_q;
      if (vblnk_in && !prev_vblnk_q) begin
         xlat_d = xpos;
         ylat_d = ypos;
      end

      // Zero-extended counters keep underflowed offsets out of the rectangle.
      h_ext  = {1'b0, hcount_in};
      v_ext  = {1'b0, vcount_in};
      x_off  = h_ext - xlat_q;
      y_off  = v_ext - ylat_q;
      inrect = (h_ext >= xlat_q) && (x_off < POS_W'(IMG_W)) &&
               (v_ext >= ylat_q) && (y_off < POS_W'(IMG_H));

      pixel_addr_d = inrect ? {y_off[5:0], x_off[5:0]} : '0;
      s1_d.blank   = hblnk_in | vblnk_in;
      s1_d.inrect  = inrect;
      s1_d.rgb     = rgb_in;
      s2_d         = s1_q;

      is_key    = KEY_EN && (rgb_pixel == KEY_RGB);
      rgb_out_d = s2_q.rgb;
      if (s2_q.blank) begin
         rgb_out_d = '0;
      end else if (s2_q.inrect && !is_key) begin
         rgb_out_d = rgb_pixel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_vblnk_q <= 1'b0;
         xlat_q       <= '0;
         ylat_q       <= '0;
         pixel_addr_q <= '0;
         s1_q         <= '0;
         s2_q         <= '0;
         rgb_out_q    <= '0;
      end else begin
         prev_vblnk_q <= prev_vblnk_d;
         xlat_q       <= xlat_d;
         ylat_q       <= ylat_d;
         pixel_addr_q <= pixel_addr_d;
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         rgb_out_q    <= rgb_out_d;
      end
   end

   vga_timing_t tim_in, tim_out;

   assign tim_in = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                     vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};

   vga_timing_delay #(.N(DRAW_LAT)) u_timing_delay (
      .clk     (clk),
      .rst     (rst),
      .tim_in  (tim_in),
      .tim_out (tim_out)
   );

   assign pixel_addr = pixel_addr_q;
   assign rgb_out    = rgb_out_q;
   assign hcount_out = tim_out.hcount;
   assign hsync_out  = tim_out.hsync;
   assign hblnk_out  = tim_out.hblnk;
   assign vcount_out = tim_out.vcount;
   assign vsync_out  = tim_out.vsync;
   assign vblnk_out  = tim_out.vblnk;

endmodule

// File: tb/tb_sprite_draw.sv
// Directed plus randomised bench for sprite_draw with a registered image ROM model
// and an expected-output queue aligned to the three-cycle pipeline.
module tb_sprite_draw;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] hcount_in = '0, vcount_in = '0;
   logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
   logic [11:0] rgb_in = '0, xpos = '0, ypos = '0;
   logic [11:0] rgb_pixel = '0;
   logic [11:0] pixel_addr;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
   logic [11:0] rgb_out;

   int total = 0;
   int bad   = 0;

   logic [37:0] exp_q[$];
   logic [11:0] m_xlat = '0, m_ylat = '0;
   logic        m_prev = 1'b0;

   always #5 clk = ~clk;

   sprite_draw dut (
      .clk        (clk),
      .rst        (rst),
      .hcount_in  (hcount_in),
      .hsync_in   (hsync_in),
      .hblnk_in   (hblnk_in),
      .vcount_in  (vcount_in),
      .vsync_in   (vsync_in),
      .vblnk_in   (vblnk_in),
      .rgb_in     (rgb_in),
      .xpos       (xpos),
      .ypos       (ypos),
      .rgb_pixel  (rgb_pixel),
      .pixel_addr (pixel_addr),
      .hcount_out (hcount_out),
      .hsync_out  (hsync_out),
      .hblnk_out  (hblnk_out),
      .vcount_out (vcount_out),
      .vsync_out  (vsync_out),
      .vblnk_out  (vblnk_out),
      .rgb_out    (rgb_out)
   );

   function automatic logic [11:0] rom_fn(input logic [11:0] a);
      if (a == 12'h041) return 12'h000;
      if (a == 12'h042) return 12'hF00;
      return a ^ 12'h5A5;
   endfunction

   // Registered image ROM: data appears one edge after the address.
   always @(posedge clk) rgb_pixel <= rom_fn(pixel_addr);

   task automatic drive(input logic [10:0] h, input logic [10:0] v,
                        input logic hb, input logic vb, input logic [11:0] rgb,
                        input string tag);
      logic [11:0] h_e, v_e, xo, yo, ea, rom, eo;
      logic        inr, hs, vs;
      logic [37:0] got, exp_v;
      h_e = {1'b0, h};
      v_e = {1'b0, v};
      xo  = h_e - m_xlat;
      yo  = v_e - m_ylat;
      inr = (h_e >= m_xlat) && (xo < 12'd48) && (v_e >= m_ylat) && (yo < 12'd64);
      ea  = inr ? {yo[5:0], xo[5:0]} : 12'h000;
      rom = rom_fn(ea);
      eo  = (hb | vb) ? 12'h000 : (inr && rom != 12'h000) ? rom : rgb;
      hs  = h[3];
      vs  = v[2];
      hcount_in = h;
      vcount_in = v;
      hsync_in  = hs;
      vsync_in  = vs;
      hblnk_in  = hb;
      vblnk_in  = vb;
      rgb_in    = rgb;
      @(posedge clk);
      #1;
      if (rst) begin
         exp_q.delete();
         repeat (3) exp_q.push_back('0);
         ea     = 12'h000;
         m_xlat = '0;
         m_ylat = '0;
         m_prev = 1'b0;
      end else begin
         exp_q.push_back({h, hs, hb, v, vs, vb, eo});
         if (vb && !m_prev) begin
            m_xlat = xpos;
            m_ylat = ypos;
         end
         m_prev = vb;
      end
      total++;
      assert (pixel_addr === ea) else begin
         bad++;
         $error("FAIL addr_%s got=%h exp=%h", tag, pixel_addr, ea);
      end
      if (exp_q.size() == 3) begin
         exp_v = exp_q.pop_front();
         got   = {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out};
         total++;
         assert (got === exp_v) else begin
            bad++;
            $error("FAIL out_%s got=%h exp=%h", tag, got, exp_v);
         end
      end
   endtask

   task automatic vblank_pulse(input logic [11:0] xp, input logic [11:0] yp);
      xpos = xp;
      ypos = yp;
      drive(11'd0, 11'd600, 1'b0, 1'b0, 12'h111, "pre_vb");
      drive(11'd0, 11'd601, 1'b0, 1'b1, 12'h111, "vb_rise");
      drive(11'd0, 11'd602, 1'b0, 1'b1, 12'h111, "vb_hold");
      drive(11'd0, 11'd603, 1'b0, 1'b0, 12'h111, "vb_fall");
   endtask

   initial begin
      rst = 1'b1;
      drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h000, "reset0");
      drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h000, "reset1");
      rst = 1'b0;

      vblank_pulse(12'd100, 12'd50);
      drive(11'd100, 11'd50,  1'b0, 1'b0, 12'h123, "corner_tl");
      drive(11'd147, 11'd113, 1'b0, 1'b0, 12'h234, "corner_br");
      drive(11'd148, 11'd113, 1'b0, 1'b0, 12'h345, "right_out");
      drive(11'd99,  11'd50,  1'b0, 1'b0, 12'h456, "left_out");
      drive(11'd100, 11'd49,  1'b0, 1'b0, 12'h567, "top_out");
      drive(11'd100, 11'd114, 1'b0, 1'b0, 12'h678, "bottom_out");
      drive(11'd101, 11'd51,  1'b0, 1'b0, 12'hABC, "key_transp");
      drive(11'd102, 11'd51,  1'b0, 1'b0, 12'hABC, "key_opaque");

      xpos = 12'd300;
      drive(11'd100, 11'd60, 1'b0, 1'b0, 12'h321, "midframe_old");
      drive(11'd300, 11'd60, 1'b0, 1'b0, 12'h321, "midframe_new");
      vblank_pulse(12'd300, 12'd50);
      drive(11'd300, 11'd60, 1'b0, 1'b0, 12'h432, "nextframe_new");
      drive(11'd100, 11'd60, 1'b0, 1'b0, 12'h432, "nextframe_old");

      vblank_pulse(12'd780, 12'd0);
      drive(11'd779, 11'd0, 1'b0, 1'b0, 12'h0F0, "clip_left");
      drive(11'd780, 11'd0, 1'b0, 1'b0, 12'h0F0, "clip_first");
      drive(11'd799, 11'd0, 1'b0, 1'b0, 12'h0F0, "clip_last");
      drive(11'd0,   11'd0, 1'b0, 1'b0, 12'h0F0, "clip_nowrap");
      drive(11'd790, 11'd5, 1'b1, 1'b0, 12'h0F0, "hblnk_in_rect");

      vblank_pulse(12'd100, 12'd3000);
      drive(11'd100,  11'd0,    1'b0, 1'b0, 12'h777, "yfar_top");
      drive(11'd100,  11'd2047, 1'b0, 1'b0, 12'h777, "yfar_max");

      vblank_pulse(12'd200, 12'd100);
      for (int i = 0; i < 40; i++) begin
         drive(11'($urandom_range(190, 260)), 11'($urandom_range(95, 170)),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
               12'($urandom_range(0, 4095)), "random");
      end

      drive(11'd210, 11'd110, 1'b0, 1'b0, 12'h9A9, "pre_reset");
      rst = 1'b1;
      drive(11'd211, 11'd110, 1'b0, 1'b0, 12'h9A9, "mid_reset");
      rst = 1'b0;
      drive(11'd5,   11'd5,   1'b0, 1'b0, 12'h135, "post_rst0");
      drive(11'd6,   11'd5,   1'b0, 1'b0, 12'h246, "post_rst1");
      drive(11'd212, 11'd110, 1'b0, 1'b0, 12'h357, "post_rst2");
      drive(11'd47,  11'd63,  1'b0, 1'b0, 12'h468, "post_rst3");
      drive(11'd48,  11'd63,  1'b0, 1'b0, 12'h579, "post_rst4");
      drive(11'd0,   11'd0,   1'b0, 1'b0, 12'h68A, "post_rst5");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
